// File: rtl/cpu_bus.sv
// rtl/cpu_bus.sv - 6502 bus responder: mirrored RAM, PPU regs, joypads, PRG, OAM DMA.
// Optional OAM DMA engine is built only when CPU_BUS_OAM_DMA_EN is defined.
module cpu_bus #(
  parameter int          RAM_AW   = 11,
  parameter logic [15:0] DMA_PORT = 16'h4014
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  output logic        cpu_ce,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_r,
  input  logic        cpu_w,
  output logic [7:0]  cpu_i,
  output logic [2:0]  ppu_a,
  output logic [7:0]  ppu_o,
  input  logic [7:0]  ppu_i,
  output logic        ppu_r,
  output logic        ppu_w,
  output logic [14:0] prg_a,
  input  logic [7:0]  prg_i,
  input  logic [7:0]  joy1,
  input  logic [7:0]  joy2
);

  logic [15:0] ea;
  logic        dma_busy;
  logic        dma_wr;
  logic [7:0]  dma_data;
  logic [7:0]  rd_data;
  logic        commit;
  logic        is_ram, is_ppu, is_joy1, is_joy2;

  logic [7:0]  ram_q [0:(1<<RAM_AW)-1];
  logic [7:0]  ram_rd_q;
  logic        strobe_q, strobe_d;
  logic [7:0]  sh1_q, sh1_d, sh2_q, sh2_d;

`ifdef CPU_BUS_OAM_DMA_EN
  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_RD, S_WR} dma_state_e;
  dma_state_e state_q, state_d;
  logic [7:0] page_q, page_d, idx_q, idx_d, data_q, data_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: if (commit && cpu_w && ea == DMA_PORT) begin
        state_d = S_ALIGN;
        page_d  = cpu_d;
        idx_d   = 8'h00;
      end
      S_ALIGN: if (tick) state_d = S_RD;
      S_RD: if (tick) begin
        data_d  = rd_data;
        state_d = S_WR;
      end
      S_WR: if (tick) begin
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == 8'hFF) ? S_IDLE : S_RD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The source address is held for the whole transfer so RAM/PRG prefetch between ticks.
  assign dma_busy = (state_q != S_IDLE);
  assign dma_wr   = (state_q == S_WR);
  assign dma_data = data_q;
  assign ea       = dma_busy ? {page_q, idx_q} : cpu_a;
`else
  assign dma_busy = 1'b0;
  assign dma_wr   = 1'b0;
  assign dma_data = 8'h00;
  assign ea       = cpu_a;
`endif

  assign cpu_ce  = tick & ~dma_busy;
  assign commit  = cpu_ce;
  assign is_ram  = (ea[15:13] == 3'b000);
  assign is_ppu  = (ea[15:13] == 3'b001);
  assign is_joy1 = (ea == 16'h4016);
  assign is_joy2 = (ea == 16'h4017);

  always_comb begin
    rd_data = 8'h00;
    if (ea[15])                rd_data = prg_i;
    else if (is_ram)           rd_data = ram_rd_q;
    else if (is_ppu)           rd_data = ppu_i;
    else if (is_joy1)          rd_data = 8'h40 | {7'b0, sh1_q[0]};
    else if (is_joy2)          rd_data = 8'h40 | {7'b0, sh2_q[0]};
    else if (ea == DMA_PORT)   rd_data = 8'h00;
  end

  assign cpu_i = rd_data;
  assign prg_a = ea[14:0];
  assign ppu_a = dma_wr ? 3'd4 : ea[2:0];
  assign ppu_o = dma_wr ? dma_data : cpu_d;
  assign ppu_r = commit & cpu_r & is_ppu;
  assign ppu_w = (commit & cpu_w & is_ppu) | (tick & dma_wr);

  always_ff @(posedge clock) begin
    if (commit && cpu_w && is_ram) ram_q[ea[RAM_AW-1:0]] <= cpu_d;
    ram_rd_q <= ram_q[ea[RAM_AW-1:0]];
  end

  // Clearing the strobe reloads once more on that edge, freezing the last sample.
  always_comb begin
    strobe_d = strobe_q;
    sh1_d    = sh1_q;
    sh2_d    = sh2_q;
    if (commit && cpu_w && is_joy1) strobe_d = cpu_d[0];
    if (strobe_q) begin
      sh1_d = joy1;
      sh2_d = joy2;
    end else if (commit && cpu_r) begin
      if (is_joy1)      sh1_d = {1'b1, sh1_q[7:1]};
      else if (is_joy2) sh2_d = {1'b1, sh2_q[7:1]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strobe_q <= 1'b0;
      sh1_q    <= 8'h00;
      sh2_q    <= 8'h00;
    end else begin
      strobe_q <= strobe_d;
      sh1_q    <= sh1_d;
      sh2_q    <= sh2_d;
    end
  end

endmodule

// File: tb/tb_cpu_bus.sv
// tb/tb_cpu_bus.sv - directed self-checking bench for cpu_bus.
module tb_cpu_bus;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tick  = 1'b0;
  logic        cpu_ce;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_d = 8'h00;
  logic        cpu_r = 1'b0;
  logic        cpu_w = 1'b0;
  logic [7:0]  cpu_i;
  logic [2:0]  ppu_a;
  logic [7:0]  ppu_o;
  logic [7:0]  ppu_i;
  logic        ppu_r, ppu_w;
  logic [14:0] prg_a;
  logic [7:0]  prg_i = 8'h00;
  logic [7:0]  joy1 = 8'h00;
  logic [7:0]  joy2 = 8'h00;

  int pass_cnt = 0;
  int total_cnt = 0;
  int pr_cnt = 0, pw_cnt = 0, stall_cnt = 0;
  logic [7:0] pw_data [$];
  logic [2:0] pw_addr [$];
  logic [2:0] last_pa_r = 3'd0;
  logic [7:0] got_d;
  logic       got_ce;

  cpu_bus dut (
    .clock(clock), .reset(reset), .tick(tick), .cpu_ce(cpu_ce),
    .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_r(cpu_r), .cpu_w(cpu_w), .cpu_i(cpu_i),
    .ppu_a(ppu_a), .ppu_o(ppu_o), .ppu_i(ppu_i), .ppu_r(ppu_r), .ppu_w(ppu_w),
    .prg_a(prg_a), .prg_i(prg_i), .joy1(joy1), .joy2(joy2)
  );

  always #20 clock = ~clock;

  always @(posedge clock) prg_i <= prg_a[7:0] ^ {1'b0, prg_a[14:8]};
  assign ppu_i = {5'b10110, ppu_a};

  always begin
    @(negedge clock);
    #15;
    if (ppu_r) begin pr_cnt++; last_pa_r = ppu_a; end
    if (ppu_w) begin pw_cnt++; pw_data.push_back(ppu_o); pw_addr.push_back(ppu_a); end
    if (tick && !cpu_ce) stall_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic clear_mon();
    pr_cnt = 0; pw_cnt = 0; stall_cnt = 0;
    pw_data.delete(); pw_addr.delete();
  endtask

  task automatic cpu_step(input logic [15:0] a, input logic [7:0] d, input logic r, input logic w);
    @(negedge clock);
    cpu_a = a; cpu_d = d; cpu_r = r; cpu_w = w;
    @(negedge clock);
    tick = 1'b1;
    #10;
    got_d = cpu_i;
    got_ce = cpu_ce;
    @(negedge clock);
    tick = 1'b0; cpu_r = 1'b0; cpu_w = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock); tick = 1'b1; #5;
    total_cnt++; if (cpu_ce !== 1'b1) $display("FAIL reset_ce_hi: got %b expected 1", cpu_ce); else pass_cnt++;
    total_cnt++; if ({ppu_r, ppu_w} !== 2'b00) $display("FAIL reset_ppu_pulses: got %b expected 00", {ppu_r, ppu_w}); else pass_cnt++;
    @(negedge clock); tick = 1'b0; #5;
    total_cnt++; if (cpu_ce !== 1'b0) $display("FAIL reset_ce_lo: got %b expected 0", cpu_ce); else pass_cnt++;
    @(negedge clock); reset = 1'b0;
    cpu_step(16'h4016, 8'h00, 1'b1, 1'b0);
    total_cnt++; if (got_d !== 8'h40) $display("FAIL reset_sh1: got %h expected 40", got_d); else pass_cnt++;
    cpu_step(16'h4017, 8'h00, 1'b1, 1'b0);
    total_cnt++; if (got_d !== 8'h40) $display("FAIL reset_sh2: got %h expected 40", got_d); else pass_cnt++;
  endtask

  task automatic test_ram_mirror();
    cpu_step(16'h0124, 8'h3C, 1'b0, 1'b1);
    cpu_step(16'h0123, 8'h55, 1'b0, 1'b1);
    total_cnt++; if (got_ce !== 1'b1) $display("FAIL ram_write_ce: got %b expected 1", got_ce); else pass_cnt++;
    cpu_step(16'h0923, 8'h00, 1'b1, 1'b0);
    total_cnt++; if (got_d !== 8'h55) $display("FAIL ram_mirror_0923: got %h expected 55", got_d); else pass_cnt++;
    cpu_step(16'h1923, 8'h00, 1'b0, 1'b0);
    total_cnt++; if (got_d !== 8'h55) $display("FAIL ram_mirror_1923_fetch: got %h expected 55", got_d); else pass_cnt++;
    cpu_step(16'h0124, 8'h00, 1'b1, 1'b0);
    total_cnt++; if (got_d !== 8'h3C) $display("FAIL ram_neighbour: got %h expected 3c", got_d); else pass_cnt++;
    cpu_step(16'h1123, 8'hAA, 1'b0, 1'b1);
    cpu_step(16'h0123, 8'h00, 1'b1, 1'b0);
    total_cnt++; if (got_d !== 8'hAA) $display("FAIL ram_mirror_write: got %h expected aa", got_d); else pass_cnt++;
  endtask

  task automatic test_prg_unmapped();
    cpu_step(16'h8123, 8'h00, 1'b1, 1'b0);
    total_cnt++; if (got_d !== 8'h22) $display("FAIL prg_8123: got %h expected 22", got_d); else pass_cnt++;
    cpu_step(16'hFFFC, 8'h00, 1'b0, 1'b0);
    total_cnt++; if (got_d !== 8'h83) $display("FAIL prg_fffc: got %h expected 83", got_d); else pass_cnt++;
    cpu_step(16'h5000, 8'h00, 1'b1, 1'b0);
    total_cnt++; if (got_d !== 8'h00) $display("FAIL unmapped_5000: got %h expected 00", got_d); else pass_cnt++;
    cpu_step(16'h6000, 8'h00, 1'b1, 1'b0);
    total_cnt++; if (got_d !== 8'h00) $display("FAIL unmapped_6000: got %h expected 00", got_d); else pass_cnt++;
    cpu_step(16'h4014, 8'h00, 1'b1, 1'b0);
    total_cnt++; if (got_d !== 8'h00) $display("FAIL read_4014: got %h expected 00", got_d); else pass_cnt++;
  endtask

  task automatic test_ppu();
    clear_mon();
    cpu_step(16'h3FFA, 8'h00, 1'b1, 1'b0);
    total_cnt++; if (got_d !== 8'hB2) $display("FAIL ppu_read_data: got %h expected b2", got_d); else pass_cnt++;
    total_cnt++; if (pr_cnt !== 1) $display("FAIL ppu_r_count: got %0d expected 1", pr_cnt); else pass_cnt++;
    total_cnt++; if (last_pa_r !== 3'd2) $display("FAIL ppu_r_addr: got %0d expected 2", last_pa_r); else pass_cnt++;
    total_cnt++; if (pw_cnt !== 0) $display("FAIL ppu_read_no_w: got %0d expected 0", pw_cnt); else pass_cnt++;
    clear_mon();
    cpu_step(16'h2000, 8'h80, 1'b0, 1'b1);
    total_cnt++; if (pw_cnt !== 1) $display("FAIL ppu_w_count: got %0d expected 1", pw_cnt); else pass_cnt++;
    total_cnt++; if (pr_cnt !== 0) $display("FAIL ppu_write_no_r: got %0d expected 0", pr_cnt); else pass_cnt++;
    total_cnt++; if (pw_data.size() != 1 || pw_data[0] !== 8'h80 || pw_addr[0] !== 3'd0)
      $display("FAIL ppu_w_payload: got %0d entries expected one with data 80 at index 0", pw_data.size());
    else pass_cnt++;
    clear_mon();
    cpu_step(16'h0123, 8'h00, 1'b1, 1'b0);
    total_cnt++; if (pr_cnt !== 0) $display("FAIL ram_read_no_ppu_r: got %0d expected 0", pr_cnt); else pass_cnt++;
  endtask

  task automatic test_joypad();
    logic [7:0] exp_j [10];
    exp_j = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41};
    joy1 = 8'b1000_0001; joy2 = 8'h02;
    cpu_step(16'h4016, 8'h01, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cpu_step(16'h4016, 8'h00, 1'b1, 1'b0);
      total_cnt++; if (got_d !== 8'h41) $display("FAIL joy_strobe_read%0d: got %h expected 41", k, got_d); else pass_cnt++;
    end
    cpu_step(16'h4016, 8'h00, 1'b0, 1'b1);
    joy1 = 8'hFE;
    for (int k = 0; k < 10; k++) begin
      cpu_step(16'h4016, 8'h00, 1'b1, 1'b0);
      total_cnt++; if (got_d !== exp_j[k]) $display("FAIL joy1_read%0d: got %h expected %h", k, got_d, exp_j[k]); else pass_cnt++;
    end
    cpu_step(16'h4017, 8'h00, 1'b1, 1'b0);
    total_cnt++; if (got_d !== 8'h40) $display("FAIL joy2_read0: got %h expected 40", got_d); else pass_cnt++;
  endtask

`ifdef CPU_BUS_OAM_DMA_EN
  task automatic test_dma();
    int n;
    int sz;
    int bad_pa;
    logic done;
    for (int i = 0; i < 256; i++) cpu_step({8'h02, 8'(i)}, 8'(i) ^ 8'hA5, 1'b0, 1'b1);
    clear_mon();
    cpu_step(16'h4014, 8'h02, 1'b0, 1'b1);
    total_cnt++; if (got_ce !== 1'b1) $display("FAIL dma_trigger_ce: got %b expected 1", got_ce); else pass_cnt++;
    n = 0; done = 1'b0;
    while (!done && n < 1200) begin
      @(negedge clock); tick = 1'b1; #10;
      if (cpu_ce) done = 1'b1;
      @(negedge clock); tick = 1'b0;
      n++;
    end
    total_cnt++; if (done !== 1'b1) $display("FAIL dma_ce_return: got %b expected 1 within 1200 ticks", done); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 513) $display("FAIL dma_stall_ticks: got %0d expected 513", stall_cnt); else pass_cnt++;
    total_cnt++; if (pw_cnt !== 256) $display("FAIL dma_ppu_w_count: got %0d expected 256", pw_cnt); else pass_cnt++;
    sz = pw_data.size();
    bad_pa = 0;
    for (int i = 0; i < sz; i++) if (pw_addr[i] !== 3'd4) bad_pa++;
    total_cnt++; if (bad_pa !== 0) $display("FAIL dma_ppu_a: got %0d writes not at index 4 expected 0", bad_pa); else pass_cnt++;
    for (int i = 0; i < 256; i++) begin
      total_cnt++;
      if (i >= sz || pw_data[i] !== (8'(i) ^ 8'hA5))
        $display("FAIL dma_byte%0d: got %h expected %h", i, (i < sz) ? pw_data[i] : 8'hxx, 8'(i) ^ 8'hA5);
      else pass_cnt++;
    end
    cpu_step(16'h0205, 8'h00, 1'b1, 1'b0);
    total_cnt++; if (got_d !== 8'hA0) $display("FAIL dma_ram_intact: got %h expected a0", got_d); else pass_cnt++;
  endtask

  task automatic test_dma_reset();
    int n;
    int stall_before;
    clear_mon();
    cpu_step(16'h4014, 8'h02, 1'b0, 1'b1);
    n = 0;
    while (pw_cnt < 100 && n < 1000) begin
      @(negedge clock); tick = 1'b1; #16;
      @(negedge clock); tick = 1'b0;
      n++;
    end
    total_cnt++; if (pw_cnt !== 100) $display("FAIL dmarst_reach100: got %0d expected 100", pw_cnt); else pass_cnt++;
    reset = 1'b1;
    stall_before = stall_cnt;
    @(negedge clock); tick = 1'b1; #10;
    total_cnt++; if (cpu_ce !== 1'b1) $display("FAIL dmarst_ce_release: got %b expected 1", cpu_ce); else pass_cnt++;
    @(negedge clock); tick = 1'b0; reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock); tick = 1'b1;
      @(negedge clock); tick = 1'b0;
    end
    total_cnt++; if (pw_cnt !== 100) $display("FAIL dmarst_no_more_w: got %0d expected 100", pw_cnt); else pass_cnt++;
    total_cnt++; if (stall_cnt !== stall_before) $display("FAIL dmarst_no_stall: got %0d expected %0d", stall_cnt, stall_before); else pass_cnt++;
    cpu_step(16'h02C8, 8'h00, 1'b1, 1'b0);
    total_cnt++; if (got_d !== 8'h6D) $display("FAIL dmarst_ram_read: got %h expected 6d", got_d); else pass_cnt++;
  endtask
`else
  task automatic test_no_dma();
    clear_mon();
    cpu_step(16'h4014, 8'h02, 1'b0, 1'b1);
    total_cnt++; if (got_ce !== 1'b1) $display("FAIL nodma_trigger_ce: got %b expected 1", got_ce); else pass_cnt++;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock); tick = 1'b1;
      @(negedge clock); tick = 1'b0;
    end
    total_cnt++; if (stall_cnt !== 0) $display("FAIL nodma_stall: got %0d expected 0", stall_cnt); else pass_cnt++;
    total_cnt++; if (pw_cnt !== 0) $display("FAIL nodma_ppu_w: got %0d expected 0", pw_cnt); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_ram_mirror();
    test_prg_unmapped();
    test_ppu();
    test_joypad();
`ifdef CPU_BUS_OAM_DMA_EN
    test_dma();
    test_dma_reset();
`else
    test_no_dma();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
